// File: rtl/psx_controller_if.sv
// psx_controller_if: PlayStation pad serial bus between host (master) and controller (slave).
interface psx_controller_if;
    logic psx_clk;
    logic cmd;
    logic att;
    logic data;
    logic ack;
    modport master (output psx_clk, cmd, att, input data, ack);
    modport slave (input psx_clk, cmd, att, output data, ack);
endinterface

// File: rtl/psx_controller.sv
// psx_controller: analog pad slave serving 9-byte poll frames, with acknowledge pulses
// between bytes and a button/stick snapshot taken at frame start.
module psx_controller #(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_DELAY = 160,
    parameter int ACK_WIDTH = 32,
    parameter logic [7:0] DEV_ID = 8'h73
) (
    input logic clk,
    input logic rst,
    psx_controller_if.slave bus,
    input logic [15:0] button_state,
    input logic [31:0] stick_state,
    output logic busy,
    output logic frame_done
);
    typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK_LOW, IGNORE} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] clk_sync, cmd_sync, att_sync;
    logic clk_d, att_d, sclk, scmd, satt;
    logic clk_fall, clk_rise, att_fall, att_rise;
    logic [3:0] byte_idx, byte_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] rx_byte, rx_n, rep;
    logic [15:0] cnt, cnt_n, snap_btn, btn_n, btn_rev;
    logic [31:0] snap_stk, stk_n;
    logic data_n, ack_n, busy_n, done_n;
    assign sclk = clk_sync[SYNC_STAGES-1];
    assign scmd = cmd_sync[SYNC_STAGES-1];
    assign satt = att_sync[SYNC_STAGES-1];
    assign clk_fall = clk_d & ~sclk;
    assign clk_rise = ~clk_d & sclk;
    assign att_fall = att_d & ~satt;
    assign att_rise = ~att_d & satt;
    assign btn_rev = {<<{snap_btn}};
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '1;
            cmd_sync <= '1;
            att_sync <= '1;
            clk_d <= 1'b1;
            att_d <= 1'b1;
        end else begin
            clk_sync <= SYNC_STAGES'({clk_sync, bus.psx_clk});
            cmd_sync <= SYNC_STAGES'({cmd_sync, bus.cmd});
            att_sync <= SYNC_STAGES'({att_sync, bus.att});
            clk_d <= sclk;
            att_d <= satt;
        end
    end
    // Buttons go out MSB first per byte, sticks LSB first, so buttons use the reversed snapshot.
    always_comb
        rep = byte_idx == 4'd1 ? DEV_ID :
              byte_idx == 4'd2 ? 8'h5A :
              byte_idx == 4'd3 ? btn_rev[7:0] :
              byte_idx == 4'd4 ? btn_rev[15:8] :
              byte_idx == 4'd5 ? snap_stk[31:24] :
              byte_idx == 4'd6 ? snap_stk[23:16] :
              byte_idx == 4'd7 ? snap_stk[15:8] :
              byte_idx == 4'd8 ? snap_stk[7:0] : 8'hFF;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            byte_idx <= '0;
            bit_idx <= '0;
            rx_byte <= '0;
            cnt <= '0;
            snap_btn <= 16'hFFFF;
            snap_stk <= 32'h80808080;
            bus.data <= 1'b1;
            bus.ack <= 1'b1;
            busy <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state <= state_n;
            byte_idx <= byte_n;
            bit_idx <= bit_n;
            rx_byte <= rx_n;
            cnt <= cnt_n;
            snap_btn <= btn_n;
            snap_stk <= stk_n;
            bus.data <= data_n;
            bus.ack <= ack_n;
            busy <= busy_n;
            frame_done <= done_n;
        end
    end
    always_comb begin
        state_n = state;
        byte_n = byte_idx;
        bit_n = bit_idx;
        rx_n = rx_byte;
        cnt_n = cnt;
        btn_n = snap_btn;
        stk_n = snap_stk;
        data_n = bus.data;
        ack_n = bus.ack;
        busy_n = busy;
        done_n = 1'b0;
        if (att_rise) begin
            state_n = IDLE;
            byte_n = '0;
            bit_n = '0;
            data_n = 1'b1;
            ack_n = 1'b1;
            busy_n = 1'b0;
        end else if (state == IDLE) begin
            if (att_fall) begin
                state_n = SHIFT;
                byte_n = '0;
                bit_n = '0;
                busy_n = 1'b1;
                btn_n = button_state;
                stk_n = stick_state;
            end
        end else if (state == IGNORE) begin
            data_n = 1'b1;
            ack_n = 1'b1;
        end else if (clk_fall) begin
            // A host clock fall cuts any pending or active ack short.
            state_n = SHIFT;
            ack_n = 1'b1;
            data_n = rep[bit_idx];
        end else if (state == SHIFT && clk_rise) begin
            rx_n[bit_idx] = scmd;
            bit_n = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
                if ((byte_idx == 4'd0 && rx_n != 8'h01) || (byte_idx == 4'd1 && rx_n != 8'h42)) begin
                    state_n = IGNORE;
                    data_n = 1'b1;
                end else if (byte_idx == 4'd8) begin
                    state_n = IGNORE;
                    data_n = 1'b1;
                    done_n = 1'b1;
                end else begin
                    state_n = ACK_WAIT;
                    byte_n = byte_idx + 4'd1;
                    cnt_n = 16'd1;
                end
            end
        end else if (state == ACK_WAIT) begin
            cnt_n = cnt + 16'd1;
            if (cnt == 16'(ACK_DELAY - 1)) begin
                state_n = ACK_LOW;
                ack_n = 1'b0;
                cnt_n = 16'd1;
            end
        end else if (state == ACK_LOW) begin
            cnt_n = cnt + 16'd1;
            if (cnt == 16'(ACK_WIDTH)) begin
                state_n = SHIFT;
                ack_n = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_psx_controller.sv
// tb_psx_controller: host-side driver polling the pad and decoding replies as a console would.
module tb_psx_controller;
    localparam int S = 2;
    localparam int D = 20;
    localparam int W = 16;
    localparam int HALF = 8;
    localparam logic [7:0] DEV = 8'h73;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] button_state;
    logic [31:0] stick_state;
    logic busy, frame_done;
    int tests = 0;
    int fails = 0;
    int fd_cnt = 0;
    int ack_cnt = 0;
    logic ack_q = 1'b1;
    psx_controller_if bus();
    psx_controller #(.SYNC_STAGES(S), .ACK_DELAY(D), .ACK_WIDTH(W), .DEV_ID(DEV)) dut (
        .clk(clk), .rst(rst), .bus(bus), .button_state(button_state),
        .stick_state(stick_state), .busy(busy), .frame_done(frame_done)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
        ack_q <= bus.ack;
        if (ack_q === 1'b1 && bus.ack === 1'b0) ack_cnt <= ack_cnt + 1;
    end
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [47:0] decode(input logic [7:0] r [9]);
        logic [15:0] b;
        for (int i = 0; i < 8; i++) begin
            b[15-i] = r[3][i];
            b[7-i] = r[4][i];
        end
        return {b, r[5], r[6], r[7], r[8]};
    endfunction
    task automatic send_bits(input logic [7:0] tx, input int first, input int n, inout logic [7:0] rx);
        for (int i = first; i < first + n; i++) begin
            @(negedge clk);
            bus.psx_clk = 1'b0;
            bus.cmd = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = bus.data;
            bus.psx_clk = 1'b1;
            if (i < first + n - 1) repeat (HALF) @(negedge clk);
        end
    endtask
    task automatic wait_ack_low(output int dly);
        dly = -1;
        for (int n = 1; n <= D + S + 10; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ack === 1'b0) begin
                dly = n;
                break;
            end
        end
    endtask
    task automatic byte_xfer(input logic [7:0] tx, output logic [7:0] rx, output int dly, output int wid);
        logic [7:0] r;
        r = 8'h00;
        send_bits(tx, 0, 8, r);
        rx = r;
        wid = 0;
        wait_ack_low(dly);
        if (dly > 0) begin
            wid = 1;
            for (int n = 0; n < W + 10; n++) begin
                @(negedge clk);
                if (bus.ack === 1'b1) break;
                wid++;
            end
        end
    endtask
    task automatic start_frame();
        @(negedge clk);
        bus.att = 1'b0;
        repeat (6) @(negedge clk);
    endtask
    task automatic end_frame();
        @(negedge clk);
        bus.att = 1'b1;
        repeat (S + 2) @(negedge clk);
    endtask
    task automatic frame(input logic [15:0] btn, input logic [31:0] stk, input logic change, input logic [15:0] mid);
        logic [7:0] r [9];
        int dly, wid, good, a0, f0;
        a0 = ack_cnt;
        f0 = fd_cnt;
        good = 0;
        button_state = btn;
        stick_state = stk;
        start_frame();
        for (int b = 0; b < 9; b++) begin
            byte_xfer(b == 0 ? 8'h01 : b == 1 ? 8'h42 : 8'h00, r[b], dly, wid);
            if (b < 8 && dly == D + S && wid == W) good++;
            if (b == 8 && dly == -1) good++;
            if (change && b == 2) button_state = mid;
        end
        check("busy_after_byte8", busy, 1);
        end_frame();
        check("reply0", r[0], 8'hFF);
        check("reply1_devid", r[1], DEV);
        check("reply2", r[2], 8'h5A);
        check("decoded_pad", decode(r), {btn, stk});
        check("ack_timing_bytes", good, 9);
        check("ack_pulses", ack_cnt - a0, 8);
        check("frame_done_pulses", fd_cnt - f0, 1);
        check("busy_after_att", busy, 0);
        check("data_idle", bus.data, 1);
    endtask
    initial begin
        logic [7:0] r, r2;
        int dly, wid, f0;
        bus.psx_clk = 1'b1;
        bus.cmd = 1'b1;
        bus.att = 1'b1;
        button_state = 16'hFFFF;
        stick_state = 32'h80808080;
        repeat (3) @(negedge clk);
        check("rst_data", bus.data, 1);
        check("rst_ack", bus.ack, 1);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        frame(16'hFFFE, 32'h10203040, 1'b0, 16'h0);
        repeat (4) frame(16'($urandom), $urandom, 1'b0, 16'h0);
        // wrong address: pad must stay silent until att rises
        start_frame();
        byte_xfer(8'h81, r, dly, wid);
        check("badaddr_reply", r, 8'hFF);
        check("badaddr_no_ack", dly, -1);
        byte_xfer(8'h42, r, dly, wid);
        check("badaddr_data_high", r, 8'hFF);
        check("badaddr_no_ack2", dly, -1);
        check("badaddr_busy", busy, 1);
        end_frame();
        check("badaddr_busy_drop", busy, 0);
        // abort after 3 bits of byte 4
        f0 = fd_cnt;
        start_frame();
        byte_xfer(8'h01, r, dly, wid);
        byte_xfer(8'h42, r, dly, wid);
        byte_xfer(8'h00, r, dly, wid);
        byte_xfer(8'h00, r, dly, wid);
        r = 8'h00;
        send_bits(8'h00, 0, 3, r);
        @(negedge clk);
        bus.att = 1'b1;
        repeat (S + 1) @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_data", bus.data, 1);
        check("abort_ack", bus.ack, 1);
        repeat (4) @(negedge clk);
        check("abort_no_frame_done", fd_cnt - f0, 0);
        frame(16'($urandom), $urandom, 1'b0, 16'h0);
        // snapshot coherency
        frame(16'hFFFF, 32'h11223344, 1'b1, 16'h0000);
        frame(16'h0000, 32'h11223344, 1'b0, 16'h0);
        // ack timing and truncation by an early host clock fall
        start_frame();
        byte_xfer(8'h01, r, dly, wid);
        check("ack_delay", dly, D + S);
        check("ack_width", wid, W);
        r = 8'h00;
        send_bits(8'h42, 0, 8, r);
        check("trunc_reply1", r, DEV);
        wait_ack_low(dly);
        check("trunc_ack_seen", dly, D + S);
        repeat (2) @(negedge clk);
        check("trunc_ack_low_before", bus.ack, 0);
        bus.psx_clk = 1'b0;
        bus.cmd = 1'b0;
        repeat (S + 1) @(posedge clk);
        #1;
        check("trunc_ack_released", bus.ack, 1);
        @(negedge clk);
        repeat (HALF - 1) @(negedge clk);
        r2 = 8'h00;
        r2[0] = bus.data;
        bus.psx_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        send_bits(8'h00, 1, 7, r2);
        check("trunc_reply2", r2, 8'h5A);
        end_frame();
        check("trunc_busy_drop", busy, 0);
        // reset during ack low, with data held at 0 from the device-id byte
        start_frame();
        byte_xfer(8'h01, r, dly, wid);
        r = 8'h00;
        send_bits(8'h42, 0, 8, r);
        wait_ack_low(dly);
        check("rstack_ack_low", bus.ack, 0);
        check("rstack_data_before", bus.data, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.att = 1'b1;
        @(posedge clk);
        #1;
        check("rstack_ack", bus.ack, 1);
        check("rstack_data", bus.data, 1);
        check("rstack_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        frame(16'($urandom), $urandom, 1'b0, 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/psx_controller.md
PSX_CONTROLLER -- requirements
Module: psx_controller

Interface
REQ-001 The module SHALL have these parameters, one per line (name, default, meaning):
- SYNC_STAGES, 2: synchronizer flops on psx_clk, cmd and att.
- ACK_DELAY, 160: clk cycles from a byte's 8th rising psx_clk edge to ack falling.
- ACK_WIDTH, 32: clk cycles ack is held low.
- DEV_ID, 8'h73: reply byte during host byte 1 (analog pad).

REQ-002 The module SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1: single system clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- psx_clk, in, 1: host serial clock, asynchronous, idle high.
- cmd, in, 1: host command bit, asynchronous, LSB first.
- att, in, 1: host attention, active low, asynchronous.
- button_state, in, 16: button levels, active low (0 = pressed).
- stick_state, in, 32: {RX, RY, LX, LY}, 8'h80 = centred.
- data, out, 1: reply bit to host, idle high.
- ack, out, 1: acknowledge to host, active low, idle high.
- busy, out, 1: high while a frame is being served.
- frame_done, out, 1: one-cycle pulse when a full 9-byte frame completes.

REQ-003 clk SHALL run at least 8x faster than psx_clk; all three asynchronous inputs SHALL pass through SYNC_STAGES flops before use, and edges SHALL be detected on the synchronized signals.

Function
REQ-004 The FSM SHALL have states IDLE, SHIFT, ACK_WAIT, ACK_LOW and IGNORE.
REQ-005 IDLE -> SHIFT on a synchronized att falling edge: byte_idx=0, bit_idx=0, busy=1, and button_state/stick_state latched into a frame snapshot; inputs SHALL NOT be resampled until the next att fall.
REQ-006 Reply bytes by byte_idx SHALL be: 0 -> 8'hFF, 1 -> DEV_ID, 2 -> 8'h5A, 3..8 -> data bytes per REQ-007.
REQ-007 Data byte mapping, wire bit i (i = 0 first):
- byte 3 = snapshot button[15-i]; byte 4 = button[7-i].
- byte 5 = stick[24+i]; byte 6 = stick[16+i]; byte 7 = stick[8+i]; byte 8 = stick[i].
This mapping round-trips exactly through psx_console.
REQ-008 In SHIFT, on each synchronized psx_clk falling edge, data SHALL be driven with reply bit bit_idx of the current byte.
REQ-009 In SHIFT, on each synchronized psx_clk rising edge, cmd SHALL be sampled into rx_byte[bit_idx] and bit_idx incremented; data SHALL hold its value between edges.
REQ-010 On the 8th rising edge of a byte, the received-byte check SHALL apply:
- byte 0 with rx_byte != 8'h01 -> IGNORE.
- byte 1 with rx_byte != 8'h42 -> IGNORE.
- bytes 2..8: rx_byte is don't-care.
REQ-011 After a byte completes without going to IGNORE:
- byte_idx 0..7 -> ACK_WAIT, byte_idx incremented, bit_idx cleared.
- byte_idx 8 -> frame_done pulse for one cycle, then IGNORE (no ack).
REQ-012 ACK_WAIT SHALL count ACK_DELAY cycles, then go to ACK_LOW.
REQ-013 ACK_LOW SHALL hold ack=0 for ACK_WIDTH cycles, then set ack=1 and go to SHIFT.
REQ-014 A synchronized psx_clk falling edge in ACK_WAIT or ACK_LOW SHALL force ack=1, enter SHIFT, and be processed as REQ-008 in the same cycle.
REQ-015 IGNORE SHALL hold data=1 and ack=1, ignore psx_clk, and stay until att rises.
REQ-016 A synchronized att rising edge in any state SHALL within one cycle give IDLE, data=1, ack=1, busy=0; a partial frame SHALL NOT pulse frame_done.
REQ-017 An att falling edge while not in IDLE SHALL be ignored; a new frame requires att high for at least one synchronized cycle.
REQ-018 Counters: bit_idx SHALL be 3 bits and wrap 7 -> 0 only at byte completion; byte_idx SHALL be 4 bits and never exceed 8.

Reset
REQ-019 With rst=1 at a clk edge: state=IDLE, data=1, ack=1, busy=0, frame_done=0, counters 0, snapshot button=16'hFFFF, stick=32'h80808080, synchronizers=1.
REQ-020 Reset SHALL take priority over all other events, including mid-frame and mid-ack.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Full poll: button=16'hFFFE, stick=32'h10203040; host sends 01 42 00x7 -> replies FF 73 5A, then payload; psx_console shows button_state=16'hFFFE, stick_state=32'h10203040; 8 ack pulses; frame_done pulses once.
- Wrong address: first byte 8'h81 -> reply FF, no ack, data=1 until att rises; busy drops on att rise.
- Abort: att raised after 3 bits of byte 4 -> IDLE within SYNC_STAGES+1 cycles; no frame_done; next frame is correct.
- Snapshot coherency: button_state changes 16'hFFFF -> 16'h0000 mid-frame -> frame returns 16'hFFFF; the next frame returns 16'h0000.
- Ack timing: ack falls exactly ACK_DELAY cycles after the synchronized 8th rise, stays low ACK_WIDTH cycles; an early psx_clk fall truncates it.
- Reset mid-ack: rst asserted during ACK_LOW -> ack=1, data=1, busy=0 the next cycle.
